// File: rtl/luna_isa_pkg.sv
// luna_isa_pkg: instruction field positions, jump codes and fetch-unit state encodings shared across the CPU.
package luna_isa_pkg;

    localparam int INSTR_W  = 16;
    localparam int TYPE_BIT = 15;
    localparam int JMP_MSB  = 2;
    localparam int JMP_LSB  = 0;

    localparam logic [JMP_MSB-JMP_LSB:0] JMP_ALWAYS = 3'b111;

    // Outstanding-read tracking for the fetch unit
    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_KILL = 2'd2
    } ifu_state_e;

    // True for a control-type word whose jump field is the unconditional code
    function automatic logic is_jmp_always(input logic [INSTR_W-1:0] w);
        return !w[TYPE_BIT] && (w[JMP_MSB:JMP_LSB] == JMP_ALWAYS);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc} holding slot behind the fetch output register.
module fetch_skid_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_q;

    // Push wins over a simultaneous pop so the slot refills in the same cycle it drains
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
        end else if (push_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
        if (rst) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (push_i && !flush_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ROM fetch front end with one outstanding read and a one-entry prefetch buffer.
// Halt detection (jump-always to its own address) is compiled in when IFU_HALT_DETECT_EN is defined.
module instr_fetch_unit
    import luna_isa_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_valid,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              set_pc,
    input  logic [15:0]       jump_target,
    output logic              halted
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d, rd_pc_q, rd_pc_d, pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ivalid_q, ivalid_d;
    logic              fire, redirect, resp, resp_to_out, issue, stop;
    logic              pb_valid, pb_push, pb_pop, pb_valid_nxt;
    logic [DATA_W-1:0] pb_data;
    logic [ADDR_W-1:0] pb_pc;

    assign fire         = ivalid_q & instr_ready;
    assign redirect     = fire & set_pc;
    assign resp         = rom_valid & (state_q == IFU_WAIT);
    assign resp_to_out  = resp & (~ivalid_q | fire) & ~pb_valid;
    assign pb_pop       = fire & pb_valid;
    assign pb_push      = resp & ~resp_to_out & ~redirect;
    assign pb_valid_nxt = ~redirect & (pb_push | (pb_valid & ~pb_pop));

`ifdef IFU_HALT_DETECT_EN
    logic halted_q, halted_d;

    // Sticky halt on a taken jump-always that targets its own address
    always_comb halted_d = halted_q | (redirect & is_jmp_always(instr_q) & (jump_target[ADDR_W-1:0] == pc_q));

    // Halt flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    assign stop = halted_q;
`else
    assign stop = 1'b0;
`endif

    assign halted = stop;

    if (ADDR_W < 16) begin : g_jt_unused
        logic unused_jt;
        assign unused_jt = ^jump_target[15:ADDR_W];
    end

    fetch_skid_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (pb_push),
        .pop_i  (pb_pop),
        .flush_i(redirect),
        .data_i (rom_data),
        .pc_i   (rd_pc_q),
        .valid_o(pb_valid),
        .data_o (pb_data),
        .pc_o   (pb_pc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IFU_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a redirect with no response this cycle leaves a stale read to discard
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: state_d = issue ? IFU_WAIT : IFU_IDLE;
            IFU_WAIT: state_d = rom_valid ? (issue ? IFU_WAIT : IFU_IDLE) : (redirect ? IFU_KILL : IFU_WAIT);
            IFU_KILL: state_d = rom_valid ? IFU_IDLE : IFU_KILL;
            default:  state_d = IFU_IDLE;
        endcase
    end

    // FSM outputs: issue only when a slot is guaranteed free for the returning word
    always_comb begin
        issue    = ~rst & ~redirect & ~stop
                 & ((state_q == IFU_IDLE) | ((state_q == IFU_WAIT) & rom_valid))
                 & ~(ivalid_d & pb_valid_nxt);
        rom_req  = issue;
        rom_addr = fpc_q;
        fpc_d    = redirect ? jump_target[ADDR_W-1:0] : (issue ? fpc_q + 1'b1 : fpc_q);
        rd_pc_d  = issue ? fpc_q : rd_pc_q;
    end

    // Output register next state: the prefetch slot drains first so order is preserved
    always_comb begin
        ivalid_d = redirect ? 1'b0 : (fire ? (pb_valid | resp) : (ivalid_q | resp_to_out));
        instr_d  = pb_pop ? pb_data : (resp_to_out ? rom_data : instr_q);
        pc_d     = pb_pop ? pb_pc : (resp_to_out ? rd_pc_q : pc_q);
    end

    // Fetch PC, in-flight read address and presented instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q    <= RESET_PC;
            rd_pc_q  <= RESET_PC;
            instr_q  <= '0;
            pc_q     <= '0;
            ivalid_q <= 1'b0;
        end else begin
            fpc_q    <= fpc_d;
            rd_pc_q  <= rd_pc_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            ivalid_q <= ivalid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = ivalid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a variable-latency ROM model.
module tb_instr_fetch_unit;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom_req, instr_valid, halted;
    logic          rom_valid = 1'b0;
    logic          instr_ready = 1'b0;
    logic          set_pc = 1'b0;
    logic [AW-1:0] rom_addr, pc;
    logic [15:0]   rom_data = '0;
    logic [15:0]   instr;
    logic [15:0]   jump_target = '0;

    int            tests = 0;
    int            fails = 0;
    int            rom_lat = 1;
    bit            halt_mode = 1'b0;
    logic [AW-1:0] exp_q[$];

    bit            pend = 1'b0;
    int            cnt = 0;
    logic [AW-1:0] paddr = '0;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_valid  (rom_valid),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .set_pc     (set_pc),
        .jump_target(jump_target),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
        return (halt_mode && a == 15'h0010) ? 16'h0707 : {1'b1, a ^ 15'h2A5A};
    endfunction

    // ROM model: answers each request rom_lat cycles later; shares reset with the DUT
    initial begin
        forever begin
            @(posedge clk); #1;
            rom_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    rom_valid = 1'b1;
                    rom_data  = rom_word(paddr);
                    pend      = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) pend = 1'b0;
            else if (rom_req) begin
                pend  = 1'b1;
                cnt   = rom_lat;
                paddr = rom_addr;
            end
        end
    end

    // Scoreboard: every accepted instruction must match the next expected pc and its ROM word
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got pc=%h instr=%h, want no accepted instruction", pc, instr);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (pc !== e || instr !== rom_word(e)) begin
                    fails++;
                    $display("FAIL sb_order: got pc=%h instr=%h, want pc=%h instr=%h", pc, instr, e, rom_word(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_range(input logic [AW-1:0] lo, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(lo + AW'(i));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; instr_ready = 1'b0; set_pc = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_pc(input logic [AW-1:0] p, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            ok = instr_valid && pc == p;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL %s: pc %h never presented, want it within 200 cycles", nm, p); end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL %s: %0d expected words left, want 0", nm, exp_q.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests += 6;
        if (rom_req !== 1'b0)      begin fails++; $display("FAIL rst_req: got %b want 0", rom_req); end
        if (rom_addr !== 15'h0)    begin fails++; $display("FAIL rst_addr: got %h want 0000", rom_addr); end
        if (instr_valid !== 1'b0)  begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        if (instr !== 16'h0)       begin fails++; $display("FAIL rst_instr: got %h want 0000", instr); end
        if (pc !== 15'h0)          begin fails++; $display("FAIL rst_pc: got %h want 0000", pc); end
        if (halted !== 1'b0)       begin fails++; $display("FAIL rst_halted: got %b want 0", halted); end
    endtask

    task automatic test_sequential();
        int miss = 0;
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 24);
        @(negedge clk);
        tests += 2;
        if (rom_req !== 1'b1 || rom_addr !== 15'h0) begin fails++; $display("FAIL seq_c1_req: got req=%b addr=%h want 1/0000", rom_req, rom_addr); end
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_c1_valid: got %b want 0", instr_valid); end
        @(negedge clk);
        tests += 2;
        if (rom_req !== 1'b1 || rom_addr !== 15'h1) begin fails++; $display("FAIL seq_c2_req: got req=%b addr=%h want 1/0001", rom_req, rom_addr); end
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_c2_valid: got %b want 0", instr_valid); end
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || pc !== 15'h0) begin fails++; $display("FAIL seq_c3: got valid=%b pc=%h want 1/0000", instr_valid, pc); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rom_req !== 1'b1 || instr_valid !== 1'b1) miss++;
        end
        tests++;
        if (miss != 0) begin fails++; $display("FAIL seq_rate: got %0d bubble cycles, want 0", miss); end
        drain("seq_drain");
    endtask

    task automatic test_stall();
        int bad = 0, reqs = 0, pbad = 0;
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 16);
        wait_pc(15'h5, "stall_wait");
        instr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (instr_valid !== 1'b1 || pc !== 15'h5 || instr !== rom_word(15'h5)) bad++;
            if (rom_req !== 1'b0) reqs++;
            if (s > 0 && dut.u_skid.valid_o !== 1'b1) pbad++;
            @(posedge clk); #1;
        end
        tests += 3;
        if (bad != 0)  begin fails++; $display("FAIL stall_stable: got %0d unstable cycles, want 0", bad); end
        if (reqs != 0) begin fails++; $display("FAIL stall_noreq: got %0d requests, want 0", reqs); end
        if (pbad != 0) begin fails++; $display("FAIL stall_pbuf: got %0d cycles with empty pbuf, want 0", pbad); end
        instr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rom_req !== 1'b1 || rom_addr !== 15'h7) begin fails++; $display("FAIL stall_resume: got req=%b addr=%h want 1/0007", rom_req, rom_addr); end
        drain("stall_drain");
    endtask

    task automatic test_redirect();
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 5);
        push_range(15'h40, 8);
        wait_pc(15'h4, "redir_wait");
        set_pc = 1'b1; jump_target = 16'h0040;
        @(negedge clk);
        tests++;
        if (rom_req !== 1'b0) begin fails++; $display("FAIL redir_noreq: got %b want 0", rom_req); end
        @(posedge clk); #1;
        set_pc = 1'b0;
        @(negedge clk);
        tests += 2;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
        if (rom_req !== 1'b1 || rom_addr !== 15'h40) begin fails++; $display("FAIL redir_req: got req=%b addr=%h want 1/0040", rom_req, rom_addr); end
        drain("redir_drain");
    endtask

    task automatic test_kill();
        bit stale = 1'b0;
        int reqs = 0;
        rom_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 3);
        push_range(15'h20, 5);
        wait_pc(15'h2, "kill_wait");
        set_pc = 1'b1; jump_target = 16'h0020;
        @(negedge clk);
        if (rom_req !== 1'b0) reqs++;
        for (int i = 0; i < 10 && !stale; i++) begin
            @(posedge clk); #1;
            set_pc = 1'b0;
            @(negedge clk);
            if (rom_req !== 1'b0) reqs++;
            stale = rom_valid;
        end
        tests += 3;
        if (!stale)    begin fails++; $display("FAIL kill_stale: got no stale response, want one"); end
        if (reqs != 0) begin fails++; $display("FAIL kill_noreq: got %0d requests before stale data, want 0", reqs); end
        @(negedge clk);
        if (rom_req !== 1'b1 || rom_addr !== 15'h20) begin fails++; $display("FAIL kill_req: got req=%b addr=%h want 1/0020", rom_req, rom_addr); end
        drain("kill_drain");
        rom_lat = 1;
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 3);
        push_range(15'h7FFE, 6);
        wait_pc(15'h2, "wrap_wait");
        set_pc = 1'b1; jump_target = 16'hFFFE;
        @(posedge clk); #1;
        set_pc = 1'b0;
        @(negedge clk);
        tests += 3;
        if (rom_req !== 1'b1 || rom_addr !== 15'h7FFE) begin fails++; $display("FAIL wrap_a: got req=%b addr=%h want 1/7ffe", rom_req, rom_addr); end
        @(negedge clk);
        if (rom_req !== 1'b1 || rom_addr !== 15'h7FFF) begin fails++; $display("FAIL wrap_b: got req=%b addr=%h want 1/7fff", rom_req, rom_addr); end
        @(negedge clk);
        if (rom_req !== 1'b1 || rom_addr !== 15'h0000) begin fails++; $display("FAIL wrap_c: got req=%b addr=%h want 1/0000", rom_req, rom_addr); end
        drain("wrap_drain");
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_range(15'h0, 40);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain: %0d words left, want 0", exp_q.size()); end
    endtask

    task automatic test_midreset();
        do_reset();
        instr_ready = 1'b1;
        push_range(15'h0, 8);
        wait_pc(15'h3, "mrst_wait");
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        tests++;
        if (rom_req !== 1'b0) begin fails++; $display("FAIL mrst_req: got %b want 0", rom_req); end
        @(posedge clk); #1;
        tests += 3;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b want 0", instr_valid); end
        if (pc !== 15'h0)         begin fails++; $display("FAIL mrst_pc: got %h want 0000", pc); end
        if (instr !== 16'h0)      begin fails++; $display("FAIL mrst_instr: got %h want 0000", instr); end
        rst = 1'b0;
        push_range(15'h0, 4);
        @(negedge clk);
        tests++;
        if (rom_req !== 1'b1 || rom_addr !== 15'h0) begin fails++; $display("FAIL mrst_restart: got req=%b addr=%h want 1/0000", rom_req, rom_addr); end
        drain("mrst_drain");
    endtask

    task automatic test_halt();
        do_reset();
        halt_mode = 1'b1;
        instr_ready = 1'b1;
        push_range(15'h0, 17);
        wait_pc(15'h10, "halt_wait");
        tests++;
        if (instr !== 16'h0707) begin fails++; $display("FAIL halt_word: got %h want 0707", instr); end
        set_pc = 1'b1; jump_target = 16'h0010;
        @(posedge clk); #1;
        set_pc = 1'b0;
`ifdef IFU_HALT_DETECT_EN
        begin
            int act = 0;
            tests++;
            if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %b want 1", halted); end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rom_req !== 1'b0 || instr_valid !== 1'b0) act++;
            end
            tests += 2;
            if (act != 0) begin fails++; $display("FAIL halt_quiet: got %0d active cycles, want 0", act); end
            if (exp_q.size() != 0) begin fails++; $display("FAIL halt_sb: %0d words left, want 0", exp_q.size()); end
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            tests++;
            if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear: got %b want 0", halted); end
            rst = 1'b0;
            instr_ready = 1'b0;
        end
`else
        push_range(15'h10, 5);
        tests++;
        if (halted !== 1'b0) begin fails++; $display("FAIL halt_tied: got %b want 0", halted); end
        drain("halt_loop");
`endif
        halt_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_kill();
        test_wrap();
        test_back_to_back();
        test_midreset();
        test_halt();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
